// File: rtl/cw_word_packer.sv
// Serial-to-parallel packer feeding the constant-weight decoder input FIFO.
// Collects CW_W bits MSB-first, writes each word, and pulses start after a full frame.
module cw_word_packer #(
    parameter int CW_W        = 10,
    parameter int FRAME_WORDS = 10,
    localparam int IDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
    localparam int BCNT_W     = (CW_W > 1) ? $clog2(CW_W) : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic              fifo_full,
    output logic [CW_W-1:0]   msg_bype,
    output logic              wr_en,
    output logic              start,
    output logic [IDX_W-1:0]  word_idx
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_START   = 2'd2;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CW_W - 1);
    localparam logic [IDX_W-1:0]  WCNT_LAST = IDX_W'(FRAME_WORDS - 1);

    logic [1:0]        r_state;
    // The oldest bit shifts out of the top when the last bit lands, so only CW_W-1 bits are kept.
    logic [CW_W-2:0]   r_sr;
    logic [BCNT_W-1:0] r_bcnt;
    logic [IDX_W-1:0]  r_wcnt;
    logic [CW_W-1:0]   r_msg;

    logic w_xfer;
    logic w_wr;

    assign bit_ready = (r_state == S_COLLECT);
    assign w_xfer    = bit_ready & bit_valid;
    assign w_wr      = (r_state == S_WRITE) & ~fifo_full;
    assign wr_en     = w_wr;
    assign start     = (r_state == S_START);
    assign msg_bype  = r_msg;
    assign word_idx  = r_wcnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_COLLECT;
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_msg   <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_sr <= {r_sr[CW_W-3:0], bit_in};
                        if (r_bcnt == BCNT_LAST) begin
                            r_msg   <= {r_sr, bit_in};
                            r_bcnt  <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Stay here with the word held until the FIFO has room.
                    if (w_wr) begin
                        if (r_wcnt == WCNT_LAST) begin
                            r_wcnt  <= '0;
                            r_state <= S_START;
                        end else begin
                            r_wcnt  <= r_wcnt + 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_COLLECT;
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw_word_packer.sv
// Directed bench for cw_word_packer: single word, full frame, back-pressure,
// gapped input, mid-frame reset and bits held through WRITE/START.
module tb_cw_word_packer;

    localparam int CW_W        = 10;
    localparam int FRAME_WORDS = 10;

    logic       clk;
    logic       rst_b;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       fifo_full;
    logic [9:0] msg_bype;
    logic       wr_en;
    logic       start;
    logic [3:0] word_idx;

    cw_word_packer #(.CW_W(CW_W), .FRAME_WORDS(FRAME_WORDS)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .fifo_full (fifo_full),
        .msg_bype  (msg_bype),
        .wr_en     (wr_en),
        .start     (start),
        .word_idx  (word_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] words [10] = '{10'h2CE, 10'h155, 10'h3FF, 10'h000, 10'h2AA,
                               10'h001, 10'h200, 10'h0F0, 10'h30C, 10'h1B7};

    // Event log sampled mid-cycle on the falling edge.
    int         cyc = 0;
    logic [9:0] wq[$];
    int         wcyc[$];
    int         n_start = 0;
    int         start_cyc = -1;
    int         n_both = 0;
    int         n_acc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            wq.push_back(msg_bype);
            wcyc.push_back(cyc);
        end
        if (start) begin
            n_start   = n_start + 1;
            start_cyc = cyc;
        end
        if (wr_en && start) n_both = n_both + 1;
        if (rst_b && bit_valid && bit_ready) n_acc = n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        n_start   = 0;
        start_cyc = -1;
        n_acc     = 0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_start"},     32'(start),     32'd0);
        chk({tag, "_bit_ready"}, 32'(bit_ready), 32'd1);
        chk({tag, "_word_idx"},  32'(word_idx),  32'd0);
        chk({tag, "_msg"},       32'(msg_bype),  32'd0);
        bit_valid = 1'b0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
    endtask

    // Present one bit and hold it until it is accepted; bit_valid stays high afterwards.
    task automatic send_bit(input logic b, input bit gap);
        bit ok;
        int stalls;
        stalls = 0;
        if (gap) begin
            while ($urandom_range(0, 1) == 0 && stalls < 8) begin
                bit_valid = 1'b0;
                stalls    = stalls + 1;
                @(posedge clk);
                #1;
            end
        end
        bit_in    = b;
        bit_valid = 1'b1;
        ok        = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bit_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $error("FAIL send_timeout: observed bit_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w, input bit gap);
        for (int i = 9; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic check_frame(input string tag, input bit timed);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < wq.size()) chk($sformatf("%s_w%0d", tag, k), 32'(wq[k]), 32'(words[k]));
        end
        if (timed && wcyc.size() == 10) begin
            for (int k = 1; k < 10; k++)
                chk($sformatf("%s_gap%0d", tag, k), 32'(wcyc[k] - wcyc[k-1]), 32'd11);
        end
        chk({tag, "_nstart"}, 32'(n_start), 32'd1);
        if (wcyc.size() == 10) chk({tag, "_start_pos"}, 32'(start_cyc), 32'(wcyc[9] + 1));
        chk({tag, "_idx_end"}, 32'(word_idx), 32'd0);
        chk({tag, "_nacc"}, 32'(n_acc), 32'd100);
    endtask

    initial begin
        rst_b     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("por_wr_en",     32'(wr_en),     32'd0);
        chk("por_bit_ready", 32'(bit_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        clear_log();

        // Single word 1011001110 -> 0x2CE, write one cycle after the 10th bit.
        send_word(10'h2CE, 1'b0);
        bit_valid = 1'b0;
        chk("sw_wr_en_now", 32'(wr_en),     32'd1);
        chk("sw_msg",       32'(msg_bype),  32'h2CE);
        chk("sw_idx0",      32'(word_idx),  32'd0);
        chk("sw_ready_lo",  32'(bit_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("sw_wr_en_off", 32'(wr_en),     32'd0);
        chk("sw_idx1",      32'(word_idx),  32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("sw_nwr",    32'(wq.size()), 32'd1);
        chk("sw_nstart", 32'(n_start),   32'd0);

        // Full frame with bit_valid held high through every WRITE/START cycle.
        do_reset("rst1");
        for (int k = 0; k < 10; k++) send_word(words[k], 1'b0);
        bit_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_frame("ff", 1'b1);

        // Back-pressure: FIFO full for 5 cycles as the first word completes.
        do_reset("rst2");
        fifo_full = 1'b1;
        send_word(10'h155, 1'b0);
        bit_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_wr_en%0d", i), 32'(wr_en),     32'd0);
            chk($sformatf("bp_ready%0d", i), 32'(bit_ready), 32'd0);
            chk($sformatf("bp_msg%0d", i),   32'(msg_bype),  32'h155);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        #1;
        chk("bp_wr_en_rise", 32'(wr_en), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_wr_en_fall", 32'(wr_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("bp_word", 32'(wq[0]), 32'h155);
        chk("bp_idx", 32'(word_idx), 32'd1);

        // Gapped input must yield the same word sequence as continuous input.
        do_reset("rst3");
        for (int k = 0; k < 10; k++) send_word(words[k], 1'b1);
        bit_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_frame("gap", 1'b0);

        // Reset after 23 bits discards the partial frame.
        do_reset("rst4");
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        bit_valid = 1'b0;
        chk("mr_idx_before", 32'(word_idx), 32'd2);
        chk("mr_msg_before", 32'(msg_bype), 32'(words[1]));
        do_reset("mr");
        chk("mr_nwr_after", 32'(wq.size()), 32'd0);
        for (int k = 0; k < 9; k++) send_word(words[k], 1'b0);
        chk("mr_no_early_start", 32'(n_start), 32'd0);
        send_word(words[9], 1'b0);
        bit_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_frame("mr", 1'b1);

        chk("wr_start_exclusive", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cw_word_packer.md
# cw_word_packer

Upstream feeder for the constant-weight decoder. It packs a serial stream of codeword bits into CW_W-bit words and writes them into the decoder's input FIFO through the FIFO write port (din / wr_en, with back-pressure from full). After FRAME_WORDS words of one frame have been written, it pulses the decoder's start. It is the only writer of that FIFO.

## Interface

Parameters:
- CW_W, 10, width of one codeword word written to the FIFO.
- FRAME_WORDS, 10, words per frame; start pulses after the last one is written.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial codeword bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  packer accepts a bit this cycle; transfer = bit_valid & bit_ready.
- fifo_full  input  1  full flag of the decoder input FIFO.
- msg_bype  output  CW_W  word presented to the FIFO din.
- wr_en  output  1  FIFO write strobe.
- start  output  1  one-cycle pulse to the decoder once a frame is in the FIFO.
- word_idx  output  clog2(FRAME_WORDS)  index of the word currently being collected.

## Operation

- Registers:
  - shift register sr[CW_W-1:0]
  - bit counter bcnt (0..CW_W-1)
  - word counter wcnt (0..FRAME_WORDS-1), driving word_idx
  - output register msg_bype
  - FSM with states COLLECT, WRITE, START
- Reset (rst_b low, asynchronous): state=COLLECT, sr=0, bcnt=0, wcnt=0, msg_bype=0. Outputs read wr_en=0, start=0, bit_ready=1.
- COLLECT:
  - bit_ready=1. Each accepted bit does sr <= {sr[CW_W-2:0], bit_in}, so the first bit received ends up in the MSB.
  - While bcnt<CW_W-1, a transfer does bcnt+1.
  - When bcnt==CW_W-1, a transfer loads msg_bype <= {sr[CW_W-2:0], bit_in}, clears bcnt and goes to WRITE.
- WRITE:
  - bit_ready=0; msg_bype held stable.
  - wr_en = !fifo_full (combinational from state and fifo_full).
  - On a cycle with wr_en=1: if wcnt==FRAME_WORDS-1, set wcnt=0 and go to START; otherwise wcnt+1 and go to COLLECT.
  - fifo_full=1 stalls in WRITE indefinitely; no word is lost or duplicated.
- START: start=1 and bit_ready=0 for exactly one cycle, then COLLECT.
- Outputs: wr_en and start are never high in the same cycle. bit_ready is high only in COLLECT.
- A partial word (bcnt>0) or partial frame persists across any idle bit_valid gaps; there is no timeout.

## Timing

- Bit acceptance is sampled on the rising edge. The CW_W-th accepted bit puts msg_bype valid and state=WRITE in the next cycle.
- With fifo_full=0, wr_en asserts in the first cycle after the last bit is accepted. The latency from the last bit's edge to the write edge is 1 cycle.
- Minimum cost per word is CW_W+1 cycles. The final word of a frame costs CW_W+2 cycles because of the START cycle.
- start rises the cycle after the final word's wr_en cycle, so that word is already in the FIFO when the decoder sees start.
- A bit_valid presented while bit_ready=0 is not consumed; the source must hold it.
- fifo_full is sampled every WRITE cycle. If fifo_full deasserts, wr_en rises in that same cycle.
- rst_b asserted mid-word or mid-frame discards all partial data. The state after release is identical to power-up, and there is no write or start glitch during or after reset.

## Test plan

- Single word (CW_W=10, FRAME_WORDS=10): feed bits 1,0,1,1,0,0,1,1,1,0 with bit_valid held high.
  - Required: msg_bype=10'h2CE, wr_en high for exactly 1 cycle, one cycle after the 10th bit.
  - Required: word_idx goes 0→1; no start pulse.
- Full frame: feed 100 bits continuously.
  - Required: 10 wr_en pulses, each 11 cycles apart.
  - Required: start high exactly once, the cycle after the 10th wr_en; word_idx back to 0.
- Back-pressure: hold fifo_full=1 for 5 cycles when the first word completes.
  - Required: wr_en=0 and bit_ready=0 for those 5 cycles, msg_bype stable, then exactly one wr_en when full drops.
- Gapped input: toggle bit_valid randomly with stall probability 50%.
  - Required: the word sequence is identical to the continuous-input result; no extra or missing writes.
- Reset mid-operation: pulse rst_b low after 23 bits.
  - Required: outputs take reset values immediately.
  - Required: the next 10 bits form word 0 (word_idx=0), and start appears only after 10 fresh words.
- Bits offered during WRITE/START: hold bit_valid high through those cycles.
  - Required: bits are not consumed while bit_ready=0, and no bit is dropped from the stream.
